// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone initiator, its peripherals and bridges.
//   wb_state_e         : bus-initiator state encoding (IDLE/REQ/WAIT/RSP)
//   WB_TIMEOUT_CYCLES  : default number of WAIT cycles tolerated before abort
// -----------------------------------------------------------------------------
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } wb_state_e;

  localparam int WB_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/wb_timeout_counter.sv
// -----------------------------------------------------------------------------
// wb_timeout_counter
// Counts WAIT-state cycles of a Wishbone initiator and flags when a responder
// has been silent for too long.
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles tolerated before expiry (>= 1)
// Ports:
//   clk_i      in  clock, rising edge
//   rst_i      in  asynchronous active-high reset
//   clear_i    in  restart the count from zero
//   enable_i   in  count this cycle
//   expired_o  out count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Expiry means TIMEOUT_CYCLES silent WAIT cycles have already elapsed, so
  // the abort happens in the cycle after them.
  assign expired_o = (count_q == CW'(TIMEOUT_CYCLES));

  // Saturate at the expiry value so the flag stays up until cleared.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
// Wishbone classic initiator: converts a valid/ready command stream into single
// read/write bus cycles and returns each result on a valid/ready response
// stream. One transaction in flight at a time; every output is a flop.
// Optional build macro:
//   WB_CMD_MASTER_TIMEOUT_EN : abort cycles that are never acknowledged
//                              (rsp_err_o=1, rsp_dat_o=0).
// Parameters:
//   WB_DATA_WIDTH, WB_ADDR_WIDTH, TIMEOUT_CYCLES (timeout build only)
// Ports:
//   clk_i, rst_i                         clock, async active-high reset
//   cmd_valid_i/cmd_ready_o              command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i       command payload
//   rsp_valid_o/rsp_ready_i              response handshake
//   rsp_dat_o, rsp_err_o                 response payload
//   cyc_o, stb_o, we_o, adr_o, dat_o     Wishbone request signals
//   dat_i, ack_i                         Wishbone responder signals
// -----------------------------------------------------------------------------
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = 8,
  parameter int WB_ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] cmd_dat_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WB_DATA_WIDTH-1:0] rsp_dat_o,
  output logic                     rsp_err_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i
);

  wb_state_e                state_q, state_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [WB_DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     tmo_clear;
  logic                     tmo_expired;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (tmo_clear),
    .enable_i (state_q == WAIT),
    .expired_o(tmo_expired)
  );
`else
  // Without the timeout the WAIT state is unbounded; the clear request and
  // the limit have no consumer in this build.
  logic unused_timeout;
  assign tmo_expired    = 1'b0;
  assign unused_timeout = tmo_clear ^ (TIMEOUT_CYCLES >= 1);
`endif

  // Next-state and next-output logic. Every register holds by default; ack_i
  // is only looked at in REQ and WAIT so stray acks elsewhere do nothing.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    tmo_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = REQ;
        end
      end

      REQ, WAIT: begin
        if (ack_i) begin
          // Ack beats a simultaneous timeout expiry.
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (state_q == REQ) begin
          // Strobe is a one-cycle pulse; cyc_o stays up while we wait.
          stb_d     = 1'b0;
          tmo_clear = 1'b1;
          state_d   = WAIT;
        end else if (tmo_expired) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register bank; reset drops the bus cycle at once and discards responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_master
// Directed bench for wb_cmd_master with a small Wishbone responder that can
// ack registered, ack combinationally, or stay silent (acks then come only
// from forceAck). Timeout scenarios are built when WB_CMD_MASTER_TIMEOUT_EN is
// defined; the bench overrides TIMEOUT_CYCLES to 4.
// -----------------------------------------------------------------------------
module tb_wb_cmd_master;

  localparam int TB_TIMEOUT = 4;
  localparam int MODE_REG    = 0;
  localparam int MODE_COMB   = 1;
  localparam int MODE_SILENT = 2;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready_o;
  logic       cmd_we;
  logic [3:0] cmd_adr;
  logic [7:0] cmd_dat;
  logic       rsp_valid_o;
  logic       rsp_ready;
  logic [7:0] rsp_dat_o;
  logic       rsp_err_o;
  logic       cyc_o, stb_o, we_o;
  logic [3:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;

  int         compCount = 0;
  int         failCount = 0;
  int         cycle = 0;
  int         respMode = MODE_REG;
  logic       forceAck = 1'b0;
  logic       ackQ;
  logic [7:0] mem [16];
  int         stbCount = 0;
  logic [3:0] stbAdr;
  logic [7:0] stbDat;
  logic       stbWe;

  wb_cmd_master #(
    .WB_DATA_WIDTH (8),
    .WB_ADDR_WIDTH (4),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .ack_i      (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to measure latencies.
  always @(posedge clk) cycle <= cycle + 1;

  // Responder model: registered ack answers one cycle after the strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) ackQ <= 1'b0;
    else     ackQ <= (respMode == MODE_REG) && cyc_o && stb_o && !ackQ;
  end

  always_comb begin
    ack_i = forceAck;
    if (respMode == MODE_REG)       ack_i = ackQ;
    else if (respMode == MODE_COMB) ack_i = cyc_o && stb_o;
    dat_i = mem[adr_o];
  end

  // Register file behind the responder, plus strobe bookkeeping.
  always @(posedge clk) begin
    if (cyc_o && ack_i && we_o) mem[adr_o] <= dat_o;
    if (cyc_o && stb_o) begin
      stbCount <= stbCount + 1;
      stbAdr   <= adr_o;
      stbDat   <= dat_o;
      stbWe    <= we_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present a command and wait until it is taken; returns the accept cycle.
  task automatic applyStimulus(input logic we, input logic [3:0] adr,
                               input logic [7:0] dat, output int accCycle);
    bit done = 1'b0;
    accCycle  = -1;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cmd_ready_o) done = 1'b1;
      @(posedge clk); #1;
      if (done) accCycle = cycle;
    end
    cmd_valid = 1'b0;
    if (!done) checkOutput("accept_bound", 0, 1);
  endtask

  task automatic waitResponse(input int accCycle, output logic [7:0] dat,
                              output logic err, output int lat,
                              output bit rdySeen);
    bit got = 1'b0;
    dat = '0; err = 1'b0; lat = -1; rdySeen = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (cmd_ready_o) rdySeen = 1'b1;
      if (rsp_valid_o) begin
        got = 1'b1;
        dat = rsp_dat_o;
        err = rsp_err_o;
        lat = cycle - accCycle;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) checkOutput("rsp_bound", 0, 1);
  endtask

  task automatic consumeResponse();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  int         acc, lat, rel, s0;
  logic [7:0] rd;
  logic       re;
  bit         rdySeen, bpOk;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmd_ready_o, 1);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_cyc", cyc_o, 0);
    checkOutput("rst_stb", stb_o, 0);
    checkOutput("rst_rsp_err", rsp_err_o, 0);
    checkOutput("rst_rsp_dat", rsp_dat_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write through a registered-ack responder.
    respMode = MODE_REG;
    s0 = stbCount;
    applyStimulus(1'b1, 4'h3, 8'hFF, acc);
    waitResponse(acc, rd, re, lat, rdySeen);
    checkOutput("wr_rsp_dat", rd, 0);
    checkOutput("wr_rsp_err", re, 0);
    checkOutput("wr_latency", lat, 2);
    checkOutput("wr_stb_count", stbCount - s0, 1);
    checkOutput("wr_stb_adr", stbAdr, 4'h3);
    checkOutput("wr_stb_dat", stbDat, 8'hFF);
    checkOutput("wr_stb_we", stbWe, 1);
    checkOutput("wr_mem", mem[3], 8'hFF);
    consumeResponse();

    // Seed address 1 then read it back.
    applyStimulus(1'b1, 4'h1, 8'hA5, acc);
    waitResponse(acc, rd, re, lat, rdySeen);
    consumeResponse();
    applyStimulus(1'b0, 4'h1, 8'h00, acc);
    waitResponse(acc, rd, re, lat, rdySeen);
    checkOutput("rd_rsp_dat", rd, 8'hA5);
    checkOutput("rd_rsp_err", re, 0);
    checkOutput("rd_latency", lat, 2);
    checkOutput("rd_ready_low", rdySeen, 0);
    consumeResponse();
    checkOutput("rd_ready_back", cmd_ready_o, 1);

    // Back-pressure: response held 5 cycles with a pending command.
    applyStimulus(1'b0, 4'h3, 8'h00, acc);
    waitResponse(acc, rd, re, lat, rdySeen);
    checkOutput("bp_rsp_dat", rd, 8'hFF);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 4'h5; cmd_dat = 8'h3C;
    bpOk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid_o || rsp_dat_o !== 8'hFF || rsp_err_o !== 1'b0) bpOk = 1'b0;
      if (cmd_ready_o || cyc_o) bpOk = 1'b0;
    end
    checkOutput("bp_stable", bpOk, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rel = cycle;
    checkOutput("bp_rsp_drop", rsp_valid_o, 0);
    checkOutput("bp_cmd_ready", cmd_ready_o, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("bp_accept_cyc", cyc_o, 1);
    checkOutput("bp_accept_lat", cycle - rel, 1);
    acc = cycle;
    waitResponse(acc, rd, re, lat, rdySeen);
    checkOutput("bp_wr_latency", lat, 2);
    consumeResponse();

    // Combinational-ack responder: one cycle latency.
    respMode = MODE_COMB;
    applyStimulus(1'b0, 4'h5, 8'h00, acc);
    waitResponse(acc, rd, re, lat, rdySeen);
    checkOutput("comb_rsp_dat", rd, 8'h3C);
    checkOutput("comb_latency", lat, 1);
    consumeResponse();

    // Reset while waiting on a silent responder.
    respMode = MODE_SILENT;
    applyStimulus(1'b1, 4'h7, 8'h11, acc);
    @(posedge clk); #1;
    checkOutput("mid_wait_cyc", cyc_o, 1);
    checkOutput("mid_wait_stb", stb_o, 0);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_cyc", cyc_o, 0);
    checkOutput("async_rst_stb", stb_o, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("post_rst_ready", cmd_ready_o, 1);
    checkOutput("post_rst_valid", rsp_valid_o, 0);
    respMode = MODE_REG;
    applyStimulus(1'b0, 4'h1, 8'h00, acc);
    waitResponse(acc, rd, re, lat, rdySeen);
    checkOutput("post_rst_rd_dat", rd, 8'hA5);
    checkOutput("post_rst_rd_lat", lat, 2);
    consumeResponse();

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // Silent responder: abort after TB_TIMEOUT silent WAIT cycles.
    respMode = MODE_SILENT;
    applyStimulus(1'b0, 4'h1, 8'h00, acc);
    waitResponse(acc, rd, re, lat, rdySeen);
    checkOutput("tmo_err", re, 1);
    checkOutput("tmo_dat", rd, 0);
    checkOutput("tmo_latency", lat, TB_TIMEOUT + 2);
    checkOutput("tmo_cyc", cyc_o, 0);
    forceAck = 1'b1;
    @(posedge clk); #1;
    forceAck = 1'b0;
    checkOutput("late_ack_valid", rsp_valid_o, 1);
    checkOutput("late_ack_err", rsp_err_o, 1);
    consumeResponse();
    forceAck = 1'b1;
    @(posedge clk); #1;
    forceAck = 1'b0;
    checkOutput("idle_ack_valid", rsp_valid_o, 0);
    checkOutput("idle_ack_ready", cmd_ready_o, 1);

    // Ack lands in the final WAIT cycle: ack wins.
    applyStimulus(1'b0, 4'h1, 8'h00, acc);
    repeat (TB_TIMEOUT + 1) @(posedge clk);
    #1;
    checkOutput("race_pre_cyc", cyc_o, 1);
    forceAck = 1'b1;
    waitResponse(acc, rd, re, lat, rdySeen);
    forceAck = 1'b0;
    checkOutput("race_err", re, 0);
    checkOutput("race_dat", rd, 8'hA5);
    checkOutput("race_latency", lat, TB_TIMEOUT + 2);
    consumeResponse();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
